ntt_address_sequencer: RTL and testbench
========================================

NTT_ADDRESS_SEQUENCER -- requirements
Module: ntt_address_sequencer

Interface
REQ-001 Parameter ADDR_W, default 7, SHALL set bank address width; polynomial holds 2^ADDR_W words, and 2^(ADDR_W-2) issues make one layer.
REQ-002 Parameter TF_W, default 7, SHALL set twiddle address width.
REQ-003 Parameters WEN_DLY1, WEN_DLY2, TF_DLY, LAYER_DLY, defaults 7, 3, 3, 4, SHALL set pipeline-alignment delays in cycles.
REQ-004 clk  in  1  the single clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 mode  in  2  00 NTT, 01 INTT, 10 PWM, 11 PWA; captured with start.
REQ-008 stall  in  1  freezes issue while high.
REQ-009 seed  in  ADDR_W-2  shuffle mask; captured with start.
REQ-010 addr0..addr3  out  ADDR_W each  four butterfly word addresses.
REQ-011 tf_addr  out  TF_W  twiddle/zeta address, delayed TF_DLY.
REQ-012 layer_last  out  1  final-pass flag, delayed LAYER_DLY.
REQ-013 wen  out  2  wen[1] after WEN_DLY1 cycles; wen[0] after WEN_DLY1+WEN_DLY2 cycles.
REQ-014 busy  out  1  high from the cycle after start is accepted until done.
REQ-015 done  out  1  one-cycle pulse when the final write enable leaves the pipeline.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start, RUN->DRAIN after final issue, DRAIN->IDLE when done pulses.
REQ-017 Issue counter b (ADDR_W-2 bits) SHALL step by one per non-stalled RUN cycle; a wrap advances the layer.
REQ-018 For NTT/INTT with len=2^s: addr0=block*2*len+(2b mod len), addr1=addr0+1, addr2=addr0+len, addr3=addr1+len, where block=(2b)>>s.
REQ-019 NTT SHALL run len = 2^(ADDR_W-1) down to 2, then one extra len=2 pass with layer flag set; tf_addr = 2^(ADDR_W-1)/len - 1 + block, plus 2^(ADDR_W-2) on the extra pass.
REQ-020 INTT SHALL run the NTT layer sequence in reverse, extra pass first, and in each layer reverse the block-to-twiddle mapping (tf = last NTT index of that layer minus block).
REQ-021 PWA SHALL issue every cycle; addresses advance by 4 every second issue; tf_addr starts at 0 and increments per issue.
REQ-022 PWM SHALL issue once per 4 RUN cycles (wen internal low otherwise); addresses advance by 4 per issue; tf_addr starts at 2^(ADDR_W-1)-1 and increments per issue.
REQ-023 PWM/PWA SHALL use len=2 and SHALL finish when addr3 = 2^ADDR_W-1 is issued.
REQ-024 While stall is high, counters SHALL hold and the internal wen SHALL be 0; delay pipes keep shifting.
REQ-025 start while busy SHALL be ignored; stall in IDLE or DRAIN SHALL have no effect.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_W; outputs in IDLE SHALL be 0.

Reset
REQ-027 rst SHALL return the FSM to IDLE, clear all counters and every delay pipe, and drive all outputs to 0 the next cycle, including mid-operation.

Configuration
REQ-028 With NTT_ADDR_SHUFFLE_EN defined, NTT/INTT SHALL substitute b XOR seed for b in REQ-018..020, so every layer is a permutation.
REQ-029 Without NTT_ADDR_SHUFFLE_EN, seed SHALL be ignored and natural order used; PWM/PWA are never shuffled.

Structure
REQ-030 Shared package ntt_addr_pkg SHALL hold mode encodings, FSM state encodings and default delay constants.
REQ-031 A resettable shift register, sub-module ntt_delay_line (WIDTH, DELAY), SHALL implement every output delay.

Verification
REQ-032 NTT, ADDR_W=7: first issue addr 0/1/64/65 tf 0; 224 issues; last issue addr 124/125/126/127 tf 94; done 10 cycles after final issue.
REQ-033 INTT: first tf 94, last tf 0; wen[1] rises 7 cycles after the first issue, wen[0] 10 cycles after it.
REQ-034 PWM: wen internal 1-in-4; 32 issues; tf 63..94; PWA: 64 issues, tf 0..63, addr step 4 every 2 issues.
REQ-035 Stall 5 cycles mid-layer -> addresses frozen, wen gap of 5, total issue count unchanged.
REQ-036 rst during layer 3 -> all outputs 0 the next cycle, no done pulse, and a new start runs cleanly.
REQ-037 With NTT_ADDR_SHUFFLE_EN and seed=5 -> each layer covers all 128 addresses exactly once; tf_addr matches the permuted block.

Source files
------------

// File: rtl/ntt_addr_pkg.sv
// Shared encodings and default pipeline-alignment delays for the NTT address sequencer.
package ntt_addr_pkg;

    typedef enum logic [1:0] {
        MODE_NTT  = 2'b00,
        MODE_INTT = 2'b01,
        MODE_PWM  = 2'b10,
        MODE_PWA  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int WEN_DLY1_DEF  = 7;
    localparam int WEN_DLY2_DEF  = 3;
    localparam int TF_DLY_DEF    = 3;
    localparam int LAYER_DLY_DEF = 4;

endpackage

// File: rtl/ntt_delay_line.sv
// Resettable shift register aligning sequencer outputs with the datapath pipeline.
module ntt_delay_line #(
    parameter int WIDTH = 1,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DELAY == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] taps [DELAY];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DELAY; i++) taps[i] <= '0;
                end else begin
                    taps[0] <= din;
                    for (int i = 1; i < DELAY; i++) taps[i] <= taps[i-1];
                end
            end

            assign dout = taps[DELAY-1];
        end
    endgenerate

endmodule

// File: rtl/ntt_address_sequencer.sv
// Butterfly / point-wise address and twiddle sequencer for one polynomial bank.
// Define NTT_ADDR_SHUFFLE_EN to replace the issue counter by (counter XOR seed) in NTT/INTT layers.
module ntt_address_sequencer
    import ntt_addr_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int TF_W      = 7,
    parameter int WEN_DLY1  = WEN_DLY1_DEF,
    parameter int WEN_DLY2  = WEN_DLY2_DEF,
    parameter int TF_DLY    = TF_DLY_DEF,
    parameter int LAYER_DLY = LAYER_DLY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              stall,
    input  logic [ADDR_W-3:0] seed,
    output logic [ADDR_W-1:0] addr0,
    output logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] addr2,
    output logic [ADDR_W-1:0] addr3,
    output logic [TF_W-1:0]   tf_addr,
    output logic              layer_last,
    output logic [1:0]        wen,
    output logic              busy,
    output logic              done
);

    localparam int BW    = ADDR_W - 2;
    localparam int LW    = $clog2(ADDR_W) + 1;
    localparam int CW    = LW + BW;
    localparam int NPASS = ADDR_W;
    localparam logic [TF_W-1:0] PWM_TF0 = TF_W'((1 << (ADDR_W - 1)) - 1);

    state_e            state;
    mode_e             mode_q;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     b, b_eff;
    logic [LW-1:0]     lyr, pass_idx;
    logic              extra;
    logic [7:0]        s;
    logic [ADDR_W-1:0] two_b, blk, len_w, stride, a0_n;
    logic [TF_W-1:0]   nblk, tf_base, tf_n;
    logic [BW-1:0]     pos;
    logic              issue_n, final_n, layer_n;
    logic              wen_int, last_int, layer_raw;
    logic [TF_W-1:0]   tf_raw;

    assign b    = cnt[BW-1:0];
    assign lyr  = cnt[CW-1:BW];
    assign busy = (state != ST_IDLE);

`ifdef NTT_ADDR_SHUFFLE_EN
    logic [BW-1:0] seed_q;

    always_ff @(posedge clk) begin
        if (rst)                              seed_q <= '0;
        else if (state == ST_IDLE && start)   seed_q <= seed;
    end

    assign b_eff = b ^ seed_q;
`else
    // Natural order: the seed has no role in this build.
    logic seed_unused;
    assign seed_unused = ^seed;
    assign b_eff       = b;
`endif

    always_comb begin
        // INTT walks the NTT pass list backwards, so the extra len=2 pass comes first.
        pass_idx = (mode_q == MODE_INTT) ? (LW'(NPASS - 1) - lyr) : lyr;
        extra    = (pass_idx == LW'(NPASS - 1));
        s        = extra ? 8'd1 : (8'(ADDR_W - 1) - 8'(pass_idx));
        two_b    = {1'b0, b_eff, 1'b0};
        blk      = two_b >> s;
        len_w    = ADDR_W'(1) << s;
        nblk     = TF_W'(1) << (8'(ADDR_W - 1) - s);
        tf_base  = nblk - TF_W'(1) + (extra ? (TF_W'(1) << BW) : '0);
        pos      = '0;
        a0_n     = '0;
        stride   = ADDR_W'(2);
        tf_n     = '0;
        issue_n  = 1'b1;
        final_n  = 1'b0;
        layer_n  = 1'b1;
        case (mode_q)
            MODE_PWA: begin
                pos     = cnt[BW:1];
                a0_n    = {pos, 2'b00};
                tf_n    = TF_W'(cnt[BW:0]);
                final_n = &cnt[BW:0];
            end
            MODE_PWM: begin
                pos     = cnt[BW+1:2];
                a0_n    = {pos, 2'b00};
                tf_n    = PWM_TF0 + TF_W'(pos);
                issue_n = (cnt[1:0] == 2'b00);
                final_n = &pos;
            end
            default: begin
                a0_n    = ((blk << s) << 1) | (two_b & (len_w - ADDR_W'(1)));
                stride  = len_w;
                tf_n    = (mode_q == MODE_INTT) ? (tf_base + nblk - TF_W'(1) - TF_W'(blk))
                                                : (tf_base + TF_W'(blk));
                final_n = (lyr == LW'(NPASS - 1)) && (&b);
                layer_n = (lyr == LW'(NPASS - 1));
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_NTT;
            cnt       <= '0;
            addr0     <= '0;
            addr1     <= '0;
            addr2     <= '0;
            addr3     <= '0;
            tf_raw    <= '0;
            layer_raw <= 1'b0;
            wen_int   <= 1'b0;
            last_int  <= 1'b0;
        end else begin
            wen_int  <= 1'b0;
            last_int <= 1'b0;
            case (state)
                ST_IDLE: begin
                    addr0     <= '0;
                    addr1     <= '0;
                    addr2     <= '0;
                    addr3     <= '0;
                    tf_raw    <= '0;
                    layer_raw <= 1'b0;
                    if (start) begin
                        state  <= ST_RUN;
                        mode_q <= mode_e'(mode);
                        cnt    <= '0;
                    end
                end
                ST_RUN: begin
                    // Stalled cycles hold every counter and address; only wen drops.
                    if (!stall) begin
                        cnt <= cnt + CW'(1);
                        if (issue_n) begin
                            addr0     <= a0_n;
                            addr1     <= a0_n + ADDR_W'(1);
                            addr2     <= a0_n + stride;
                            addr3     <= a0_n + stride + ADDR_W'(1);
                            tf_raw    <= tf_n;
                            layer_raw <= layer_n;
                            wen_int   <= 1'b1;
                            last_int  <= final_n;
                            if (final_n) state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    addr0     <= '0;
                    addr1     <= '0;
                    addr2     <= '0;
                    addr3     <= '0;
                    tf_raw    <= '0;
                    layer_raw <= 1'b0;
                    if (done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The final-issue marker rides with wen so done fires as the last write leaves.
    logic [1:0] wen_stage1, wen_stage2;

    ntt_delay_line #(.WIDTH(2), .DELAY(WEN_DLY1)) u_wen_dly1 (
        .clk (clk), .rst (rst), .din ({last_int, wen_int}), .dout (wen_stage1)
    );

    ntt_delay_line #(.WIDTH(2), .DELAY(WEN_DLY2)) u_wen_dly2 (
        .clk (clk), .rst (rst), .din (wen_stage1), .dout (wen_stage2)
    );

    ntt_delay_line #(.WIDTH(TF_W), .DELAY(TF_DLY)) u_tf_dly (
        .clk (clk), .rst (rst), .din (tf_raw), .dout (tf_addr)
    );

    ntt_delay_line #(.WIDTH(1), .DELAY(LAYER_DLY)) u_layer_dly (
        .clk (clk), .rst (rst), .din (layer_raw), .dout (layer_last)
    );

    assign wen  = {wen_stage1[0], wen_stage2[0]};
    assign done = wen_stage2[1];

endmodule

// File: tb/tb_ntt_address_sequencer.sv
// Self-checking bench for ntt_address_sequencer (ADDR_W=7, default delays); issues scored against a queue.
module tb_ntt_address_sequencer;

    localparam int AW = 7;
    localparam int TW = 7;
`ifdef NTT_ADDR_SHUFFLE_EN
    localparam bit SHUF = 1'b1;
`else
    localparam bit SHUF = 1'b0;
`endif

    logic          clk, rst, start, stall;
    logic [1:0]    mode;
    logic [AW-3:0] seed;
    logic [AW-1:0] addr0, addr1, addr2, addr3;
    logic [TW-1:0] tf_addr;
    logic          layer_last, busy, done;
    logic [1:0]    wen;

    typedef struct packed {
        logic [AW-1:0] a0, a1, a2, a3;
        logic [TW-1:0] tf;
        logic          lay;
    } iss_t;

    iss_t exp_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, wen1_cnt = 0, wen0_cnt = 0, done_cnt = 0;
    logic [4*AW-1:0] hist_a  [16];
    logic [TW-1:0]   hist_tf [16];
    logic            hist_l  [16];

    ntt_address_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .stall      (stall),
        .seed       (seed),
        .addr0      (addr0),
        .addr1      (addr1),
        .addr2      (addr2),
        .addr3      (addr3),
        .tf_addr    (tf_addr),
        .layer_last (layer_last),
        .wen        (wen),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference sequence built from the address/twiddle formulas, one entry per issue.
    task automatic push_expected(input logic [1:0] m, input logic [AW-3:0] sd);
        iss_t e;
        int len, nb, base, bb, blk, q;
        if (m == 2'b00 || m == 2'b01) begin
            for (int p = 0; p < 7; p++) begin
                q    = (m == 2'b01) ? 6 - p : p;
                len  = (q == 6) ? 2 : (64 >> q);
                nb   = 64 / len;
                base = nb - 1 + ((q == 6) ? 32 : 0);
                for (int b = 0; b < 32; b++) begin
                    bb    = SHUF ? (b ^ int'(sd)) : b;
                    blk   = (2 * bb) / len;
                    e.a0  = 7'(blk * 2 * len + (2 * bb) % len);
                    e.a1  = 7'(int'(e.a0) + 1);
                    e.a2  = 7'(int'(e.a0) + len);
                    e.a3  = 7'(int'(e.a1) + len);
                    e.tf  = (m == 2'b01) ? 7'(base + nb - 1 - blk) : 7'(base + blk);
                    e.lay = (p == 6);
                    exp_q.push_back(e);
                end
            end
        end else if (m == 2'b11) begin
            for (int i = 0; i < 64; i++) begin
                e.a0 = 7'(4 * (i / 2)); e.a1 = 7'(4 * (i / 2) + 1);
                e.a2 = 7'(4 * (i / 2) + 2); e.a3 = 7'(4 * (i / 2) + 3);
                e.tf = 7'(i); e.lay = 1'b1;
                exp_q.push_back(e);
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                e.a0 = 7'(4 * i); e.a1 = 7'(4 * i + 1);
                e.a2 = 7'(4 * i + 2); e.a3 = 7'(4 * i + 3);
                e.tf = 7'(63 + i); e.lay = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Each wen[1] pulse belongs to the issue 7 cycles earlier; tf at +3, layer at +4.
    always @(negedge clk) begin
        iss_t e;
        hist_a[cyc % 16]  = {addr0, addr1, addr2, addr3};
        hist_tf[cyc % 16] = tf_addr;
        hist_l[cyc % 16]  = layer_last;
        if (wen[0]) wen0_cnt++;
        if (done)   done_cnt++;
        if (wen[1]) begin
            wen1_cnt++;
            check("issue_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("issue_addr", 32'(hist_a[(cyc + 9) % 16]), 32'({e.a0, e.a1, e.a2, e.a3}));
                check("issue_tf", 32'(hist_tf[(cyc + 12) % 16]), 32'(e.tf));
                check("issue_layer", 32'(hist_l[(cyc + 13) % 16]), 32'(e.lay));
            end
        end
        cyc++;
    end

    task automatic run_op(input logic [1:0] m, input logic [AW-3:0] sd, input int stall_at,
                          input int exp_done, input int exp_issues);
        int n, done_at, w1_at, w0_at, prev_w1, b1, b0, bd;
        logic [4*AW-1:0] frozen;
        b1 = wen1_cnt; b0 = wen0_cnt; bd = done_cnt;
        done_at = -1; w1_at = -1; w0_at = -1; prev_w1 = -1;
        push_expected(m, sd);
        @(negedge clk);
        mode = m; seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 2'b00; seed = '0; n = 1;
        while (n < 600) begin
            if (n == 1) check("busy_after_start", 32'(busy), 32'd1);
            if (n == 20) begin start = 1'b1; mode = 2'b11; end
            if (n == 21) begin start = 1'b0; mode = 2'b00; end
            if (wen[1] && w1_at < 0) w1_at = n;
            if (wen[0] && w0_at < 0) w0_at = n;
            if (m == 2'b10 && wen[1]) begin
                if (prev_w1 >= 0) check("pwm_wen_spacing", 32'(n - prev_w1), 32'd4);
                prev_w1 = n;
            end
            if (done) begin
                done_at = n;
                break;
            end
            if (n == stall_at) begin
                frozen = {addr0, addr1, addr2, addr3};
                stall  = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); n++;
                    check("stall_addr_frozen", 32'({addr0, addr1, addr2, addr3}), 32'(frozen));
                end
                stall = 1'b0;
            end
            @(negedge clk); n++;
        end
        check("done_latency", 32'(done_at), 32'(exp_done));
        check("wen1_first", 32'(w1_at), 32'd9);
        check("wen0_first", 32'(w0_at), 32'd12);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_pulse", 32'(done_cnt - bd), 32'd1);
        check("wen1_issues", 32'(wen1_cnt - b1), 32'(exp_issues));
        check("wen0_issues", 32'(wen0_cnt - b0), 32'(exp_issues));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int bd;
        rst = 1'b1; start = 1'b0; mode = 2'b00; stall = 1'b0; seed = '0;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'({addr0, addr1, addr2, addr3}), 32'd0);
        check("rst_tf_layer_wen", 32'({tf_addr, layer_last, wen}), 32'd0);
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        rst = 1'b0;

        @(negedge clk);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_stall_busy", 32'(busy), 32'd0);
        check("idle_stall_addr", 32'({addr0, addr1, addr2, addr3}), 32'd0);
        stall = 1'b0;

        run_op(2'b00, 5'd5, 0, 235, 224);
        run_op(2'b01, 5'd0, 0, 235, 224);
        run_op(2'b10, 5'd0, 0, 136, 32);
        run_op(2'b11, 5'd0, 0, 75, 64);
        run_op(2'b00, 5'd0, 50, 240, 224);

        // Abort an NTT partway through layer 3.
        push_expected(2'b00, 5'd0);
        @(negedge clk);
        mode = 2'b00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (102) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_addr", 32'({addr0, addr1, addr2, addr3}), 32'd0);
        check("abort_tf_layer_wen", 32'({tf_addr, layer_last, wen}), 32'd0);
        check("abort_busy_done", 32'({busy, done}), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        bd = done_cnt;
        repeat (20) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - bd), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        run_op(2'b11, 5'd0, 0, 75, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
